dbus_arb: RTL and testbench

- Two-master arbiter sitting directly upstream of the data-bus interconnect; drives the interconnect's single master port.
- Master 0 is the core load/store unit. Master 1 is the debug module's system-bus master.
- Grants one master per transaction and locks the grant until the transaction's resp or fault.
- Forwards the request combinationally, so there is zero added latency on an uncontended bus.

---
 rtl/dbus_arb_pkg.sv | 22 ++
 rtl/dbus_arb_pick.sv | 36 +++
 rtl/dbus_arb.sv | 150 +++++++++++++++
 tb/tb_dbus_arb.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_arb_pkg.sv
// rtl/dbus_arb_pkg.sv - bus widths and state encoding shared by dbus_arb
//
// Provides the data-bus geometry (XLEN, BUS_WIDTH, BUS_ACC_CNT), the arbiter
// state encoding, and a helper that sizes the master-0 weight counter.
package dbus_arb_pkg;

   localparam int XLEN        = 32;
   localparam int BUS_WIDTH   = 32;
   localparam int BUS_ACC_CNT = 4;
   localparam int ACC_W       = $clog2(BUS_ACC_CNT);

   typedef enum logic {
      DBUS_ARB_IDLE = 1'b0,
      DBUS_ARB_BUSY = 1'b1
   } dbus_arb_state_e;

   // Counter must hold values 0..weight inclusive.
   function automatic int wcnt_width(input int weight);
      return (weight < 1) ? 1 : $clog2(weight + 1);
   endfunction

endpackage

// File: rtl/dbus_arb_pick.sv
// rtl/dbus_arb_pick.sv - combinational arbitration rule for dbus_arb
//
// Decides which master wins a free bus this cycle.
//   req0, req1 : master requests
//   last       : winner of the previous completed transaction (1 = master 1)
//   wcnt       : consecutive master-0 grants since master 1 was last served
//   sel        : 0 = master 0 wins, 1 = master 1 wins
// Macro DBUS_ARB_RR_EN selects weighted round-robin; otherwise master 1
// (debug) wins every tie and last/wcnt are ignored.
module dbus_arb_pick
   import dbus_arb_pkg::*;
#(
   parameter int M0_WEIGHT = 1,
   parameter int WCNT_W    = 1
) (
   input  logic              req0,
   input  logic              req1,
   input  logic              last,
   input  logic [WCNT_W-1:0] wcnt,
   output logic              sel
);

`ifdef DBUS_ARB_RR_EN
   localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(M0_WEIGHT);

   // Master 1 is owed the bus once master 0 has used up its weight in a row.
   logic m1_turn;
   assign m1_turn = !last && (wcnt >= WMAX);
   assign sel     = req1 && (!req0 || m1_turn);
`else
   logic unused_rr;
   assign unused_rr = last ^ (^wcnt) ^ (M0_WEIGHT < 0);
   assign sel       = req1;
`endif

endmodule

// File: rtl/dbus_arb.sv
// rtl/dbus_arb.sv - two-master arbiter in front of the data-bus interconnect
//
// Grants the bus to one master per transaction and holds the grant until the
// interconnect returns resp or fault. The request path is combinational, so an
// uncontended access sees no extra latency.
//   clk, rst          : clock, synchronous active-high reset
//   m0_* / m1_*       : master 0 (load/store unit) / master 1 (debug SBA)
//                       req/addr/w_rb/acc/wdata in, resp/rdata/fault out
//   s_*               : single master port toward the interconnect
// Macro DBUS_ARB_RR_EN enables weighted round-robin (M0_WEIGHT consecutive
// master-0 grants per master-1 grant); default is fixed priority to master 1.
module dbus_arb
   import dbus_arb_pkg::*;
#(
   parameter int M0_WEIGHT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_req,
   input  logic [XLEN-1:0]      m0_addr,
   input  logic                 m0_w_rb,
   input  logic [ACC_W-1:0]     m0_acc,
   input  logic [BUS_WIDTH-1:0] m0_wdata,
   output logic                 m0_resp,
   output logic [BUS_WIDTH-1:0] m0_rdata,
   output logic                 m0_fault,
   input  logic                 m1_req,
   input  logic [XLEN-1:0]      m1_addr,
   input  logic                 m1_w_rb,
   input  logic [ACC_W-1:0]     m1_acc,
   input  logic [BUS_WIDTH-1:0] m1_wdata,
   output logic                 m1_resp,
   output logic [BUS_WIDTH-1:0] m1_rdata,
   output logic                 m1_fault,
   output logic                 s_req,
   output logic [XLEN-1:0]      s_addr,
   output logic                 s_w_rb,
   output logic [ACC_W-1:0]     s_acc,
   output logic [BUS_WIDTH-1:0] s_wdata,
   input  logic                 s_resp,
   input  logic [BUS_WIDTH-1:0] s_rdata,
   input  logic                 s_fault
);

   localparam int WCNT_W = wcnt_width(M0_WEIGHT);

   dbus_arb_state_e   state, state_nxt;
   logic              owner, owner_nxt;
   logic              last;
   logic [WCNT_W-1:0] wcnt;
   logic              pick_sel;
   logic              sel;
   logic              busy;
   logic              req_sel;
   logic              xfer_live;

   dbus_arb_pick #(
      .M0_WEIGHT(M0_WEIGHT),
      .WCNT_W   (WCNT_W)
   ) u_pick (
      .req0(m0_req),
      .req1(m1_req),
      .last(last),
      .wcnt(wcnt),
      .sel (pick_sel)
   );

   assign busy    = (state == DBUS_ARB_BUSY);
   assign sel     = busy ? owner : pick_sel;
   assign req_sel = sel ? m1_req : m0_req;
   // A response only belongs to someone while a transaction is open; a stray
   // resp in IDLE with nothing forwarded (e.g. just after reset) is dropped.
   assign xfer_live = busy || req_sel;

   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DBUS_ARB_IDLE;
         owner <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      case (state)
         DBUS_ARB_IDLE: begin
            // Same-cycle completion never enters BUSY.
            if (req_sel && !s_resp && !s_fault) begin
               state_nxt = DBUS_ARB_BUSY;
               owner_nxt = sel;
            end
         end
         DBUS_ARB_BUSY: begin
            if (s_resp || s_fault) state_nxt = DBUS_ARB_IDLE;
         end
         default: state_nxt = DBUS_ARB_IDLE;
      endcase
   end

   always_comb begin
      s_addr   = sel ? m1_addr  : m0_addr;
      s_w_rb   = sel ? m1_w_rb  : m0_w_rb;
      s_acc    = sel ? m1_acc   : m0_acc;
      s_wdata  = sel ? m1_wdata : m0_wdata;
      s_req    = 1'b0;
      m0_resp  = 1'b0;
      m1_resp  = 1'b0;
      m0_fault = 1'b0;
      m1_fault = 1'b0;
      if (!rst) begin
         s_req = req_sel;
         if (xfer_live) begin
            m0_resp  = s_resp  && !sel;
            m1_resp  = s_resp  &&  sel;
            m0_fault = s_fault && !sel;
            m1_fault = s_fault &&  sel;
         end
      end
   end

`ifdef DBUS_ARB_RR_EN
   localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(M0_WEIGHT);

   logic done;
   assign done = xfer_live && (s_resp || s_fault);

   always_ff @(posedge clk) begin
      if (rst) begin
         last <= 1'b1;
         wcnt <= '0;
      end else if (done) begin
         last <= sel;
         if (sel)
            wcnt <= '0;
         else if (wcnt < WMAX)
            wcnt <= wcnt + WCNT_W'(1);
      end
   end
`else
   assign last = 1'b1;
   assign wcnt = '0;
`endif

endmodule

// File: tb/tb_dbus_arb.sv
// tb/tb_dbus_arb.sv - scoreboard testbench for dbus_arb
module tb_dbus_arb;
   import dbus_arb_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 m0_req, m0_w_rb, m0_resp, m0_fault;
   logic [XLEN-1:0]      m0_addr;
   logic [ACC_W-1:0]     m0_acc;
   logic [BUS_WIDTH-1:0] m0_wdata, m0_rdata;
   logic                 m1_req, m1_w_rb, m1_resp, m1_fault;
   logic [XLEN-1:0]      m1_addr;
   logic [ACC_W-1:0]     m1_acc;
   logic [BUS_WIDTH-1:0] m1_wdata, m1_rdata;
   logic                 s_req, s_w_rb, s_resp, s_fault;
   logic [XLEN-1:0]      s_addr;
   logic [ACC_W-1:0]     s_acc;
   logic [BUS_WIDTH-1:0] s_wdata, s_rdata;

   always #5 clk = ~clk;

   dbus_arb #(.M0_WEIGHT(2)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc),
      .m0_wdata(m0_wdata), .m0_resp(m0_resp), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc),
      .m1_wdata(m1_wdata), .m1_resp(m1_resp), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
      .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc),
      .s_wdata(s_wdata), .s_resp(s_resp), .s_rdata(s_rdata), .s_fault(s_fault)
   );

   typedef struct {
      logic                 m;
      logic [BUS_WIDTH-1:0] rdata;
      logic                 fault;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // {m1_fault, m0_fault, m1_resp, m0_resp} expected for a scoreboard entry
   function automatic logic [3:0] exp_vec(input exp_t e);
      if (e.fault) return e.m ? 4'b1000 : 4'b0100;
      return e.m ? 4'b0010 : 4'b0001;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_addr = '0; m0_w_rb = 1'b0; m0_acc = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_addr = '0; m1_w_rb = 1'b0; m1_acc = '0; m1_wdata = '0;
      s_resp = 1'b0; s_fault = 1'b0; s_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      m0_req = 1'b1; m0_addr = 32'h0000_1000; s_resp = 1'b1; s_fault = 1'b1;
      tick(); settle();
      checks++;
      if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== 4'b0000) begin
         failures++; $display("FAIL reset_resp got=%b exp=0000", {m1_fault, m0_fault, m1_resp, m0_resp});
      end
      tick(); settle();
      checks++;
      if (dut.state !== DBUS_ARB_IDLE) begin failures++; $display("FAIL reset_state got=%b exp=0", dut.state); end
      checks++;
      if (dut.owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b exp=0", dut.owner); end
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_lone_m0();
      exp_t e;
      logic [BUS_WIDTH-1:0] rd = 32'hA5A5_1234;
      m0_req = 1'b1; m0_addr = 32'h2000_0010; m0_w_rb = 1'b0; m0_acc = 2'd2;
      sb.push_back('{m: 1'b0, rdata: rd, fault: 1'b0});
      settle();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h2000_0010 || s_w_rb !== 1'b0 || s_acc !== 2'd2) begin
         failures++; $display("FAIL lone_fwd got=%b/%h/%b/%0d exp=1/20000010/0/2", s_req, s_addr, s_w_rb, s_acc);
      end
      tick(); settle();
      checks++;
      if (dut.state !== DBUS_ARB_BUSY) begin failures++; $display("FAIL lone_busy1 got=%b exp=1", dut.state); end
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== 4'b0000) begin
         failures++; $display("FAIL lone_early_resp got=%b exp=0000", {m1_fault, m0_fault, m1_resp, m0_resp});
      end
      tick();
      s_resp = 1'b1; s_rdata = rd;
      settle();
      checks++;
      if (dut.state !== DBUS_ARB_BUSY) begin failures++; $display("FAIL lone_busy2 got=%b exp=1", dut.state); end
      e = sb.pop_front();
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== exp_vec(e)) begin
         failures++; $display("FAIL lone_resp got=%b exp=%b", {m1_fault, m0_fault, m1_resp, m0_resp}, exp_vec(e));
      end
      checks++;
      if (m0_rdata !== e.rdata) begin failures++; $display("FAIL lone_rdata got=%h exp=%h", m0_rdata, e.rdata); end
      tick(); idle_inputs(); settle();
      checks++;
      if (dut.state !== DBUS_ARB_IDLE) begin failures++; $display("FAIL lone_idle got=%b exp=0", dut.state); end
   endtask

   task automatic test_tie_fixed();
      exp_t e;
      tick();
      m0_req = 1'b1; m0_addr = 32'h2000_0100; m0_w_rb = 1'b1; m0_wdata = 32'hDEAD_BEEF;
      m1_req = 1'b1; m1_addr = 32'h1000_0040; m1_w_rb = 1'b0;
      sb.push_back('{m: 1'b1, rdata: 32'h1111_2222, fault: 1'b0});
      sb.push_back('{m: 1'b0, rdata: 32'h0, fault: 1'b0});
      settle();
      checks++;
      if (s_addr !== 32'h1000_0040 || s_w_rb !== 1'b0) begin
         failures++; $display("FAIL tie_grant got=%h/%b exp=10000040/0", s_addr, s_w_rb);
      end
      tick();
      s_resp = 1'b1; s_rdata = 32'h1111_2222;
      settle();
      e = sb.pop_front();
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== exp_vec(e)) begin
         failures++; $display("FAIL tie_m1_resp got=%b exp=%b", {m1_fault, m0_fault, m1_resp, m0_resp}, exp_vec(e));
      end
      checks++;
      if (m1_rdata !== e.rdata) begin failures++; $display("FAIL tie_m1_rdata got=%h exp=%h", m1_rdata, e.rdata); end
      tick();
      m1_req = 1'b0; s_resp = 1'b0; s_rdata = '0;
      settle();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h2000_0100 || s_w_rb !== 1'b1 || s_wdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL tie_m0_fwd got=%b/%h/%b/%h exp=1/20000100/1/deadbeef", s_req, s_addr, s_w_rb, s_wdata);
      end
      tick(); settle();
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== 4'b0000) begin
         failures++; $display("FAIL tie_m0_wait got=%b exp=0000", {m1_fault, m0_fault, m1_resp, m0_resp});
      end
      tick();
      s_resp = 1'b1;
      settle();
      e = sb.pop_front();
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== exp_vec(e)) begin
         failures++; $display("FAIL tie_m0_resp got=%b exp=%b", {m1_fault, m0_fault, m1_resp, m0_resp}, exp_vec(e));
      end
      tick(); idle_inputs();
   endtask

   task automatic test_round_robin();
      exp_t e;
      logic order [6];
      order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      m0_req = 1'b1; m0_addr = 32'h2000_0000;
      m1_req = 1'b1; m1_addr = 32'h1000_0000;
      s_resp = 1'b1;
      for (int i = 0; i < 6; i++)
         sb.push_back('{m: order[i], rdata: 32'h100 + i, fault: 1'b0});
      for (int i = 0; i < 6; i++) begin
         s_rdata = 32'h100 + i;
         settle();
         e = sb.pop_front();
         checks++;
         if ({m1_fault, m0_fault, m1_resp, m0_resp} !== exp_vec(e) || m0_rdata !== e.rdata) begin
            failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {m1_fault, m0_fault, m1_resp, m0_resp}, exp_vec(e));
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_same_cycle();
      exp_t e;
      tick();
      m0_req = 1'b1; m0_addr = 32'h2000_0200; s_resp = 1'b1; s_rdata = 32'h0BAD_F00D;
      sb.push_back('{m: 1'b0, rdata: 32'h0BAD_F00D, fault: 1'b0});
      settle();
      e = sb.pop_front();
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== exp_vec(e) || m0_rdata !== e.rdata) begin
         failures++; $display("FAIL same_resp got=%b/%h exp=%b/%h", {m1_fault, m0_fault, m1_resp, m0_resp}, m0_rdata, exp_vec(e), e.rdata);
      end
      tick();
      m0_addr = 32'h2000_0204; s_resp = 1'b0; s_rdata = '0;
      sb.push_back('{m: 1'b0, rdata: 32'h5555_AAAA, fault: 1'b0});
      settle();
      checks++;
      if (dut.state !== DBUS_ARB_IDLE) begin failures++; $display("FAIL same_idle got=%b exp=0", dut.state); end
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h2000_0204) begin
         failures++; $display("FAIL same_next_fwd got=%b/%h exp=1/20000204", s_req, s_addr);
      end
      tick();
      s_resp = 1'b1; s_rdata = 32'h5555_AAAA;
      settle();
      e = sb.pop_front();
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== exp_vec(e) || m0_rdata !== e.rdata) begin
         failures++; $display("FAIL same_next_resp got=%b/%h exp=%b/%h", {m1_fault, m0_fault, m1_resp, m0_resp}, m0_rdata, exp_vec(e), e.rdata);
      end
      tick(); idle_inputs();
   endtask

   task automatic test_fault();
      exp_t e;
      tick();
      m1_req = 1'b1; m1_addr = 32'hF000_0000;
      sb.push_back('{m: 1'b1, rdata: '0, fault: 1'b1});
      settle();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'hF000_0000) begin
         failures++; $display("FAIL fault_fwd got=%b/%h exp=1/f0000000", s_req, s_addr);
      end
      tick();
      s_fault = 1'b1;
      settle();
      e = sb.pop_front();
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== exp_vec(e)) begin
         failures++; $display("FAIL fault_route got=%b exp=%b", {m1_fault, m0_fault, m1_resp, m0_resp}, exp_vec(e));
      end
      tick(); idle_inputs(); settle();
      checks++;
      if (dut.state !== DBUS_ARB_IDLE) begin failures++; $display("FAIL fault_idle got=%b exp=0", dut.state); end
   endtask

   task automatic test_drop_req();
      exp_t e;
      tick();
      m0_req = 1'b1; m0_addr = 32'h2000_0300;
      tick();
      m0_req = 1'b0;
      settle();
      checks++;
      if (s_req !== 1'b0 || dut.state !== DBUS_ARB_BUSY) begin
         failures++; $display("FAIL drop_hold got=%b/%b exp=0/1", s_req, dut.state);
      end
      tick();
      s_resp = 1'b1; s_rdata = 32'h7777_0000;
      sb.push_back('{m: 1'b0, rdata: 32'h7777_0000, fault: 1'b0});
      settle();
      e = sb.pop_front();
      checks++;
      if ({m1_fault, m0_fault, m1_resp, m0_resp} !== exp_vec(e)) begin
         failures++; $display("FAIL drop_resp got=%b exp=%b", {m1_fault, m0_fault, m1_resp, m0_resp}, exp_vec(e));
      end
      tick(); idle_inputs(); settle();
      checks++;
      if (dut.state !== DBUS_ARB_IDLE) begin failures++; $display("FAIL drop_idle got=%b exp=0", dut.state); end
   endtask

   task automatic test_reset_mid();
      tick();
      m1_req = 1'b1; m1_addr = 32'h1000_0080;
      tick(); settle();
      checks++;
      if (dut.state !== DBUS_ARB_BUSY || dut.owner !== 1'b1) begin
         failures++; $display("FAIL rmid_busy got=%b/%b exp=1/1", dut.state, dut.owner);
      end
      tick();
      rst = 1'b1; s_resp = 1'b1;
      settle();
      checks++;
      if (s_req !== 1'b0 || {m1_fault, m0_fault, m1_resp, m0_resp} !== 4'b0000) begin
         failures++; $display("FAIL rmid_in_reset got=%b/%b exp=0/0000", s_req, {m1_fault, m0_fault, m1_resp, m0_resp});
      end
      tick(); settle();
      checks++;
      if (dut.state !== DBUS_ARB_IDLE || dut.owner !== 1'b0) begin
         failures++; $display("FAIL rmid_state got=%b/%b exp=0/0", dut.state, dut.owner);
      end
      tick();
      rst = 1'b0; m1_req = 1'b0; s_resp = 1'b1;
      settle();
      checks++;
      if (s_req !== 1'b0 || {m1_fault, m0_fault, m1_resp, m0_resp} !== 4'b0000) begin
         failures++; $display("FAIL rmid_late_resp got=%b/%b exp=0/0000", s_req, {m1_fault, m0_fault, m1_resp, m0_resp});
      end
      tick(); idle_inputs();
   endtask

   initial begin
      test_reset();
      test_lone_m0();
`ifdef DBUS_ARB_RR_EN
      test_round_robin();
`else
      test_tie_fixed();
`endif
      test_same_cycle();
      test_fault();
      test_drop_req();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
